// File: rtl/cmd_frame_sched_if.sv
// ---------------------------------------------------------------------------
// cmd_frame_sched_if
//
// Bundles every signal between the command-frame sequencer and its neighbours
// (command FIFO, frame parser, configuration register bank).
//
// Handshake rules:
//   * Parser start/done: prs_fs is high for the whole PARSE phase. The parser
//     answers with prs_fd (level, may be held for several cycles) or with
//     prs_err (sticky until prs_rst). The sequencer waits for prs_fd to drop
//     before it decides what to do with the decoded frame.
//   * Configuration req/ack: cfg_req rises and stays high until a cycle in
//     which cfg_ack is high. That cycle is the transfer; cfg_req drops on the
//     following clock edge. cfg_ack outside an open request has no effect.
//
// Modports:
//   master - the sequencer (cmd_frame_sched)
//   slave  - the surrounding FIFO / parser / register bank
//
// state_dbg exposes the sequencer FSM state for checkers and debug
// (0 IDLE, 1 PARSE, 2 RELEASE, 3 APPLY, 4 RECOVER).
// ---------------------------------------------------------------------------
interface cmd_frame_sched_if #(
  parameter int CNT_W = 10
);
  logic             ctrl_en;
  logic [CNT_W-1:0] fifoc_count;
  logic             fifoc_flush;
  logic             prs_fs;
  logic             prs_fd;
  logic             prs_err;
  logic             prs_rst;
  logic [7:0]       kind_dev;
  logic             cfg_req;
  logic             cfg_ack;
  logic             busy;
  logic [7:0]       frame_cnt;
  logic [7:0]       err_cnt;
  logic [1:0]       last_err;
  logic [2:0]       state_dbg;

  modport master (
    input  ctrl_en, fifoc_count, prs_fd, prs_err, kind_dev, cfg_ack,
    output fifoc_flush, prs_fs, prs_rst, cfg_req, busy,
           frame_cnt, err_cnt, last_err, state_dbg
  );

  modport slave (
    output ctrl_en, fifoc_count, prs_fd, prs_err, kind_dev, cfg_ack,
    input  fifoc_flush, prs_fs, prs_rst, cfg_req, busy,
           frame_cnt, err_cnt, last_err, state_dbg
  );
endinterface

// File: rtl/cmd_frame_sched.sv
// ---------------------------------------------------------------------------
// cmd_frame_sched
//
// Sequencer for the Ethernet command-frame parser. It waits until the command
// FIFO holds a full frame, starts the parser, supervises errors and timeouts,
// filters on the decoded device kind and hands accepted configurations to the
// register bank. Parser soft reset and FIFO flush are issued from RECOVER.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset (shared with the parser)
//   bus  - cmd_frame_sched_if.master:
//            ctrl_en      in   allow new frames to start
//            fifoc_count  in   bytes in command FIFO
//            fifoc_flush  out  FIFO flush (RECOVER)
//            prs_fs       out  parser frame start (PARSE)
//            prs_fd       in   parser frame done
//            prs_err      in   parser error, sticky until prs_rst
//            prs_rst      out  parser soft reset (RECOVER)
//            kind_dev     in   decoded device kind
//            cfg_req      out  configuration valid, held until cfg_ack
//            cfg_ack      in   configuration accepted
//            busy         out  FSM not in IDLE
//            frame_cnt    out  applied frames, saturating
//            err_cnt      out  errors of any kind, saturating
//            last_err     out  00 none, 01 parser, 10 timeout, 11 kind
//            state_dbg    out  current FSM state
//
// All outputs are registered: every transition assigns the output values
// that belong to the destination state, so they line up with the state
// register cycle for cycle.
// ---------------------------------------------------------------------------
module cmd_frame_sched #(
  parameter int         FRAME_LEN = 12,
  parameter int         CNT_W     = 10,
  parameter int         TIMEOUT   = 64,
  parameter int         RST_CYC   = 4,
  parameter logic [7:0] DEV_KIND  = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  cmd_frame_sched_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PARSE   = 3'd1,
    S_RELEASE = 3'd2,
    S_APPLY   = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // One timer serves both the PARSE timeout and the RECOVER hold, so it is
  // sized for the larger of the two.
  localparam int TMR_MAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_FILL = CNT_W'(FRAME_LEN);

  localparam logic [1:0] ERR_PARSER  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_KIND    = 2'b11;

  state_t           state;
  logic [TMR_W-1:0] timer;

  logic       fifoc_flush_q;
  logic       prs_fs_q;
  logic       prs_rst_q;
  logic       cfg_req_q;
  logic       busy_q;
  logic [7:0] frame_cnt_q;
  logic [7:0] err_cnt_q;
  logic [1:0] last_err_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Broadcast kind is always accepted alongside our own kind.
  logic kind_ok;
  assign kind_ok = (bus.kind_dev == DEV_KIND) || (bus.kind_dev == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      timer         <= '0;
      fifoc_flush_q <= 1'b0;
      prs_fs_q      <= 1'b0;
      prs_rst_q     <= 1'b0;
      cfg_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= 8'h00;
      err_cnt_q     <= 8'h00;
      last_err_q    <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ctrl_en && (bus.fifoc_count >= MIN_FILL)) begin
            state    <= S_PARSE;
            timer    <= '0;
            prs_fs_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end

        S_PARSE: begin
          timer <= timer + 1'b1;
          // Error wins over done; done wins over timeout.
          if (bus.prs_err || (!bus.prs_fd && (timer == TMO_LAST))) begin
            state         <= S_RECOVER;
            timer         <= '0;
            prs_fs_q      <= 1'b0;
            prs_rst_q     <= 1'b1;
            fifoc_flush_q <= 1'b1;
            err_cnt_q     <= sat_inc(err_cnt_q);
            last_err_q    <= bus.prs_err ? ERR_PARSER : ERR_TIMEOUT;
          end else if (bus.prs_fd) begin
            state    <= S_RELEASE;
            prs_fs_q <= 1'b0;
          end
        end

        S_RELEASE: begin
          // The parser must drop fd before the next frame can be started;
          // kind_dev is judged once fd is gone.
          if (!bus.prs_fd) begin
            if (kind_ok) begin
              state     <= S_APPLY;
              cfg_req_q <= 1'b1;
            end else begin
              state      <= S_IDLE;
              busy_q     <= 1'b0;
              err_cnt_q  <= sat_inc(err_cnt_q);
              last_err_q <= ERR_KIND;
            end
          end
        end

        S_APPLY: begin
          if (bus.cfg_ack) begin
            state       <= S_IDLE;
            cfg_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= sat_inc(frame_cnt_q);
          end
        end

        S_RECOVER: begin
          if (timer == RST_LAST) begin
            state         <= S_IDLE;
            timer         <= '0;
            prs_rst_q     <= 1'b0;
            fifoc_flush_q <= 1'b0;
            busy_q        <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state         <= S_IDLE;
          timer         <= '0;
          fifoc_flush_q <= 1'b0;
          prs_fs_q      <= 1'b0;
          prs_rst_q     <= 1'b0;
          cfg_req_q     <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifoc_flush = fifoc_flush_q;
  assign bus.prs_fs      = prs_fs_q;
  assign bus.prs_rst     = prs_rst_q;
  assign bus.cfg_req     = cfg_req_q;
  assign bus.busy        = busy_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.last_err    = last_err_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_cmd_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_cmd_frame_sched
//
// Frame-level bench for cmd_frame_sched. Each frame the stimulus issues is
// summarised by the reference model as one expected episode record (parser
// start pulses, PARSE length, cfg_req length, reset/flush length and the
// counter/status values at the end) and pushed on exp_q. The monitor builds
// the same record from the DUT pins over each busy period and pops/compares
// when busy falls.
// ---------------------------------------------------------------------------
module tb_cmd_frame_sched;

  localparam int         FRAME_LEN = 12;
  localparam int         CNT_W     = 10;
  localparam int         TIMEOUT   = 64;
  localparam int         RST_CYC   = 4;
  localparam logic [7:0] DEV_KIND  = 8'h01;
  localparam int         W         = 54;

  localparam int M_NORMAL  = 0;
  localparam int M_ERR     = 1;
  localparam int M_ERRFD   = 2;
  localparam int M_TIMEOUT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_frame_sched_if #(.CNT_W(CNT_W)) bus ();

  cmd_frame_sched #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .RST_CYC   (RST_CYC),
    .DEV_KIND  (DEV_KIND)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // reference model counters
  int         frame_m = 0;
  int         err_m   = 0;
  logic [1:0] last_m  = 2'b00;

  bit mon_en = 1'b0;
  int starts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int rises, input int fs_c, input int req_c,
                                        input int rst_c, input int fl_c, input logic [7:0] fc,
                                        input logic [7:0] ec, input logic [1:0] le);
    return {4'(rises), 8'(fs_c), 8'(req_c), 8'(rst_c), 8'(fl_c), fc, ec, le};
  endfunction

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // ---------------- monitor ----------------
  int   m_rises, m_fs, m_req, m_rst, m_fl;
  logic prev_busy = 1'b0;
  logic prev_fs   = 1'b0;

  always @(negedge clk) begin
    if (!mon_en) begin
      m_rises = 0; m_fs = 0; m_req = 0; m_rst = 0; m_fl = 0;
      prev_busy = 1'b0;
      prev_fs   = 1'b0;
    end else begin
      if (bus.busy && !prev_busy) starts++;
      if (bus.busy) begin
        if (bus.prs_fs && !prev_fs) m_rises++;
        if (bus.prs_fs)      m_fs++;
        if (bus.cfg_req)     m_req++;
        if (bus.prs_rst)     m_rst++;
        if (bus.fifoc_flush) m_fl++;
      end
      if (prev_busy && !bus.busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_episode", 64'd1, 64'd0);
        end else begin
          check("episode",
                64'(pack(m_rises, m_fs, m_req, m_rst, m_fl, bus.frame_cnt, bus.err_cnt, bus.last_err)),
                64'(exp_q.pop_front()));
        end
        m_rises = 0; m_fs = 0; m_req = 0; m_rst = 0; m_fl = 0;
      end
      prev_busy = bus.busy;
      prev_fs   = bus.prs_fs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.ctrl_en     = 1'b0;
    bus.fifoc_count = '0;
    bus.prs_fd      = 1'b0;
    bus.prs_err     = 1'b0;
    bus.kind_dev    = 8'h00;
    bus.cfg_ack     = 1'b0;
  endtask

  // Reference model: one frame outcome from the behavioural rules.
  task automatic model_frame(input int mode, input logic [7:0] kd, input int d, input int a);
    int fs_c, req_c, rr_c;
    req_c = 0;
    rr_c  = 0;
    fs_c  = (mode == M_TIMEOUT) ? TIMEOUT : d + 1;
    if (mode == M_NORMAL) begin
      if (kd == DEV_KIND || kd == 8'hFF) begin
        frame_m = sat(frame_m);
        req_c   = a + 1;
      end else begin
        err_m  = sat(err_m);
        last_m = 2'b11;
      end
    end else begin
      err_m  = sat(err_m);
      last_m = (mode == M_TIMEOUT) ? 2'b10 : 2'b01;
      rr_c   = RST_CYC;
    end
    exp_q.push_back(pack(1, fs_c, req_c, rr_c, rr_c, 8'(frame_m), 8'(err_m), last_m));
  endtask

  task automatic wait_sig(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.prs_fs) || (which == 1 && bus.cfg_req) ||
          (which == 2 && bus.prs_rst)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input int mode, input int cnt, input logic [7:0] kd,
                           input int d, input int h, input int a, input bit drop_en);
    bit ok;
    model_frame(mode, kd, d, a);
    @(negedge clk);
    bus.kind_dev    = kd;
    bus.fifoc_count = CNT_W'(cnt);
    bus.ctrl_en     = 1'b1;
    wait_sig(0, 10, ok);
    if (!ok) begin
      check("fs_wait", 64'd0, 64'd1);
      bus.fifoc_count = '0;
      return;
    end
    bus.fifoc_count = '0;
    if (drop_en) bus.ctrl_en = 1'b0;
    case (mode)
      M_NORMAL: begin
        repeat (d) @(negedge clk);
        bus.prs_fd = 1'b1;
        repeat (h) @(negedge clk);
        bus.prs_fd = 1'b0;
        if (kd == DEV_KIND || kd == 8'hFF) begin
          wait_sig(1, 10, ok);
          if (!ok) check("req_wait", 64'd0, 64'd1);
          else begin
            repeat (a) @(negedge clk);
            bus.cfg_ack = 1'b1;
            @(negedge clk);
            bus.cfg_ack = 1'b0;
          end
        end
      end
      M_ERR, M_ERRFD: begin
        repeat (d) @(negedge clk);
        bus.prs_err = 1'b1;
        if (mode == M_ERRFD) bus.prs_fd = 1'b1;
        wait_sig(2, 10, ok);
        if (!ok) check("prs_rst_wait", 64'd0, 64'd1);
        bus.prs_err = 1'b0;
        bus.prs_fd  = 1'b0;
      end
      default: ;
    endcase
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("busy_wait", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.fifoc_flush, bus.prs_fs, bus.prs_rst, bus.cfg_req, bus.busy,
                bus.frame_cnt, bus.err_cnt, bus.last_err, bus.state_dbg});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int st0;
    int mode, sel;
    logic [7:0] kd;
    bit ok;

    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", out_vec(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset", out_vec(), 64'd0);
    mon_en = 1'b1;

    // Directed frames
    run_frame(M_NORMAL,  12, 8'h01, 13, 1, 2, 1'b0);  // good frame at exact threshold
    run_frame(M_ERR,     40, 8'h01,  5, 1, 0, 1'b0);  // parser error
    check("idle_after_err", 64'(bus.busy), 64'd0);
    run_frame(M_TIMEOUT, 20, 8'h01,  0, 1, 0, 1'b0);  // timeout
    run_frame(M_NORMAL,  15, 8'h02,  3, 2, 0, 1'b0);  // kind mismatch
    run_frame(M_NORMAL,  15, 8'hFF,  2, 1, 0, 1'b0);  // broadcast kind, ack on first APPLY cycle
    run_frame(M_ERRFD,   12, 8'h01,  4, 1, 0, 1'b0);  // err and fd together
    run_frame(M_NORMAL,  12, 8'h01,  6, 3, 1, 1'b1);  // ctrl_en drops mid-PARSE

    // Gating and threshold: nothing may start, stray acks ignored
    st0 = starts;
    @(negedge clk);
    bus.ctrl_en = 1'b1; bus.fifoc_count = CNT_W'(FRAME_LEN - 1);
    repeat (30) @(negedge clk);
    check("gate_count11", 64'(starts - st0), 64'd0);
    bus.fifoc_count = '0;
    repeat (10) @(negedge clk);
    check("gate_count0", 64'(starts - st0), 64'd0);
    bus.ctrl_en = 1'b0; bus.fifoc_count = CNT_W'(FRAME_LEN);
    bus.cfg_ack = 1'b1;
    repeat (30) @(negedge clk);
    bus.cfg_ack = 1'b0;
    check("gate_ctrl_en0", 64'(starts - st0), 64'd0);
    check("stray_ack_frame_cnt", 64'(bus.frame_cnt), 64'(frame_m));
    check("idle_busy", 64'(bus.busy), 64'd0);
    bus.fifoc_count = '0;

    // Randomized frames
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      mode = (sel <= 5) ? M_NORMAL : (sel <= 6) ? M_ERR : (sel == 7) ? M_ERRFD :
             (sel == 8) ? M_TIMEOUT : M_NORMAL;
      case ($urandom_range(0, 2))
        0:       kd = 8'h01;
        1:       kd = 8'hFF;
        default: kd = 8'($urandom_range(0, 255));
      endcase
      run_frame(mode, $urandom_range(FRAME_LEN, 1023), kd, $urandom_range(0, 40),
                $urandom_range(1, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Counter saturation
    for (int n = 0; n < 256; n++)
      run_frame(M_NORMAL, $urandom_range(FRAME_LEN, 1023), ($urandom_range(0, 1) != 0) ? 8'h01 : 8'hFF,
                $urandom_range(0, 3), 1, $urandom_range(0, 1), 1'b0);
    check("frame_cnt_sat", 64'(bus.frame_cnt), 64'hFF);
    for (int n = 0; n < 256; n++)
      run_frame(M_NORMAL, FRAME_LEN, 8'($urandom_range(2, 254)), $urandom_range(0, 2), 1, 0, 1'b0);
    check("err_cnt_sat", 64'(bus.err_cnt), 64'hFF);

    // Asynchronous reset while waiting in APPLY
    @(negedge clk);
    bus.kind_dev = 8'h01; bus.fifoc_count = CNT_W'(FRAME_LEN); bus.ctrl_en = 1'b1;
    wait_sig(0, 10, ok);
    if (!ok) check("rst_fs_wait", 64'd0, 64'd1);
    bus.fifoc_count = '0;
    repeat (3) @(negedge clk);
    bus.prs_fd = 1'b1;
    @(negedge clk);
    bus.prs_fd = 1'b0;
    wait_sig(1, 10, ok);
    check("apply_reached", 64'(bus.cfg_req), 64'd1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", out_vec(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame_m = 0; err_m = 0; last_m = 2'b00;
    @(negedge clk);
    check("after_async_reset", out_vec(), 64'd0);
    mon_en = 1'b1;
    run_frame(M_NORMAL, FRAME_LEN, 8'h01, 2, 1, 1, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
